wb_furcula_bridge: RTL and testbench
====================================

# wb_furcula_bridge

Wishbone-slave to Furcula-master bridge, the inbound counterpart of the Furcula-to-Wishbone bridge. It accepts a classic 64-bit Wishbone cycle with an arbitrary byte-lane select. It splits the selected lanes into naturally aligned, maximally sized Furcula beats (byte, hword, word or dword), with right-justified data, and issues those beats sequentially. It acknowledges the Wishbone master once, after the last Furcula beat completes. The bridge sits in front of Furcula-native peripherals and memories that must be reachable from a 64-bit Wishbone master such as DMA or debug.

## Interface
Parameters:
- `AW`, default 64: byte-address width on both sides.

Ports:
- `clk_i` — input, 1 — sole clock; all logic is rising-edge.
- `reset_i` — input, 1 — asynchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` — input, 1 each — Wishbone slave cycle, strobe and write enable.
- `wbs_adr_i` — input, AW — byte address; bits [2:0] ignored.
- `wbs_sel_i` — input, 8 — lane select; bit n selects bits [8n+7:8n].
- `wbs_dat_i` — input, 64 — write data, lane-positioned.
- `wbs_dat_o` — output, 64 — read data, lane-positioned; unselected lanes are 0.
- `wbs_ack_o` — output, 1 — single-cycle termination.
- `f_cyc_o`, `f_stb_o`, `f_we_o` — output, 1 each — Furcula master cycle, strobe and write enable.
- `f_adr_o` — output, AW — beat byte address, naturally aligned to `f_siz_o`.
- `f_siz_o` — output, 2 — beat size: 00 byte, 01 hword, 10 word, 11 dword.
- `f_signed_o` — output, 1 — tied to 0; reads are always zero-extended.
- `f_dat_o` — output, 64 — write data, right-justified; bits above the beat size are 0.
- `f_dat_i` — input, 64 — read data, right-justified.
- `f_ack_i` — input, 1 — beat termination.

## Operation
- States are IDLE, XFER and DONE. All outputs are registered.
- **IDLE**
  - On `wbs_cyc_i & wbs_stb_i` while `wbs_ack_o`=0, the bridge latches address, sel, write data and we. The remaining-lane mask `rem` is set to sel, and the read buffer is cleared.
  - If sel=0, go to DONE; no Furcula traffic occurs.
  - Otherwise compute the first beat, assert `f_cyc_o`/`f_stb_o`, and go to XFER.
- **Beat selection.** Let l be the lowest set bit of `rem`. Test in order:
  - l=0 and rem=FF: dword.
  - l mod 4=0 and rem[l+3:l]=1111: word.
  - l even and rem[l+1:l]=11: hword.
  - Otherwise: byte.
  - Beat outputs:
    - `f_adr_o` = {adr[AW-1:3], l[2:0]}.
    - `f_dat_o` = the latched lanes shifted right by 8·l and masked to the beat size.
- **XFER**
  - Outputs hold stable until `f_ack_i`.
  - On ack, for reads, the low bytes of `f_dat_i` are merged into buffer lanes l..l+n-1, and those lanes are cleared from `rem`.
  - If `rem` is now 0, drop `f_cyc_o`/`f_stb_o` and go to DONE.
  - Otherwise present the next beat on the following cycle with `f_stb_o` kept high.
- **DONE**
  - Assert `wbs_ack_o` for exactly one cycle, with `wbs_dat_o` = buffer (writes drive 0), then return to IDLE.
- **Abort.** If `wbs_cyc_i` falls during XFER:
  - The in-flight beat completes (the bridge waits for `f_ack_i`).
  - No further beats are issued.
  - The bridge returns to IDLE without `wbs_ack_o`.
- **Reset.** Asynchronous reset at any time forces IDLE and zeroes every output and internal register; an in-flight Furcula beat is abandoned.

## Timing
- Request sampled at edge N → `f_stb_o` high from N to the next edge.
- Each beat occupies at least one cycle. With `f_ack_i` returned in the same cycle as `f_stb_o`, k beats take k cycles.
- Final `f_ack_i` sampled at edge M → `wbs_ack_o` high during the cycle after edge M. IDLE can accept a new request from edge M+2.
- Minimum total latency is 2 cycles for any sel≠0; sel=0 acks 1 cycle after the request is sampled.
- Furcula wait states simply stretch XFER; the Wishbone master must hold stb and data until `wbs_ack_o`.
- Reset values:
  - All outputs are 0, including `wbs_dat_o`, `f_adr_o` and `f_dat_o`.
  - State is IDLE.

## Test plan
- **Dword read.** Read with sel=FF, adr=0x1000, and `f_dat_i`=0x0123456789ABCDEF acked immediately.
  - One beat: siz=11, adr=0x1000.
  - `wbs_ack_o` two cycles after the request, with `wbs_dat_o`=0x0123456789ABCDEF.
- **Word write.** Write with sel=F0, adr=0x2008, `wbs_dat_i`=0xDEADBEEF_00000000.
  - One beat: siz=10, adr=0x200C, `f_dat_o`=0xDEADBEEF, `f_we_o`=1.
- **Sparse byte read.** Read with sel=5A, responder returns 0x11 per beat.
  - Four byte beats at adr low bits 1, 3, 4, 6.
  - `wbs_dat_o`=0x0011001111001100.
- **Mixed sizes with wait states.** Read with sel=F6, 2-cycle `f_ack_i` latency.
  - Beats in order: byte@1, byte@2, word@4.
  - `f_stb_o` held through each wait; a single `wbs_ack_o` after the third ack.
- **Empty select.** Request with sel=00.
  - No `f_stb_o`; `wbs_ack_o` one cycle later; `wbs_dat_o`=0.
- **Abort and reset.**
  - Drop `wbs_cyc_i` during the second beat of sel=5A: that beat completes, no third beat is issued, and no `wbs_ack_o`.
  - Assert `reset_i` mid-beat: `f_cyc_o`/`f_stb_o` fall immediately.

Source files
------------

// File: rtl/wb_furcula_bridge.sv
// ---------------------------------------------------------------------------
// wb_furcula_bridge
//
// Purpose:
//   Inbound bridge from a classic 64-bit Wishbone slave port to a Furcula
//   master port. One Wishbone cycle with an arbitrary byte-lane select is
//   split into naturally aligned, maximally sized Furcula beats (byte, hword,
//   word, dword) that are issued one after another. The Wishbone master is
//   acknowledged exactly once, after the last beat has been acknowledged.
//
// Ports:
//   clk_i, reset_i        - rising-edge clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i  - Wishbone cycle, strobe, write enable
//   wbs_adr_i [AW]        - Wishbone byte address (bits [2:0] not meaningful)
//   wbs_sel_i [8]         - lane select, bit n covers data bits [8n+7:8n]
//   wbs_dat_i [64]        - lane-positioned write data
//   wbs_dat_o [64]        - lane-positioned read data, unselected lanes 0
//   wbs_ack_o             - single-cycle Wishbone termination
//   f_cyc_o/stb_o/we_o    - Furcula cycle, strobe, write enable
//   f_adr_o [AW]          - beat address, aligned to the beat size
//   f_siz_o [2]           - beat size: 00 byte, 01 hword, 10 word, 11 dword
//   f_signed_o            - always 0, reads are zero-extended
//   f_dat_o [64]          - right-justified write data, zero above beat size
//   f_dat_i [64]          - right-justified read data
//   f_ack_i               - beat termination
// ---------------------------------------------------------------------------
module wb_furcula_bridge #(
  parameter int AW = 64
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [7:0]    wbs_sel_i,
  input  logic [63:0]   wbs_dat_i,
  output logic [63:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          f_cyc_o,
  output logic          f_stb_o,
  output logic          f_we_o,
  output logic [AW-1:0] f_adr_o,
  output logic [1:0]    f_siz_o,
  output logic          f_signed_o,
  output logic [63:0]   f_dat_o,
  input  logic [63:0]   f_dat_i,
  input  logic          f_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // One Furcula beat: lowest lane covered, size code and the lanes it covers.
  typedef struct packed {
    logic [2:0] lane;
    logic [1:0] siz;
    logic [7:0] mask;
  } beat_t;

  localparam logic [1:0] SIZ_BYTE  = 2'b00;
  localparam logic [1:0] SIZ_HWORD = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_DWORD = 2'b11;

  // Largest naturally aligned beat starting at the lowest remaining lane.
  // A wider beat is only taken when every lane it covers is still wanted,
  // so unselected lanes are never touched on the Furcula side.
  function automatic beat_t pickBeat(input logic [7:0] rem);
    beat_t      b;
    logic [7:0] above;
    b.lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem[i]) b.lane = 3'(i);
    end
    above = rem >> b.lane;
    if (b.lane == 3'd0 && rem == 8'hFF) begin
      b.siz  = SIZ_DWORD;
      b.mask = 8'hFF;
    end else if (b.lane[1:0] == 2'b00 && above[3:0] == 4'hF) begin
      b.siz  = SIZ_WORD;
      b.mask = 8'h0F << b.lane;
    end else if (b.lane[0] == 1'b0 && above[1:0] == 2'b11) begin
      b.siz  = SIZ_HWORD;
      b.mask = 8'h03 << b.lane;
    end else begin
      b.siz  = SIZ_BYTE;
      b.mask = 8'h01 << b.lane;
    end
    return b;
  endfunction

  function automatic logic [63:0] sizeMask(input logic [1:0] siz);
    logic [63:0] m;
    case (siz)
      SIZ_BYTE:  m = 64'h0000_0000_0000_00FF;
      SIZ_HWORD: m = 64'h0000_0000_0000_FFFF;
      SIZ_WORD:  m = 64'h0000_0000_FFFF_FFFF;
      default:   m = '1;
    endcase
    return m;
  endfunction

  // Lane-positioned data -> right-justified beat data.
  function automatic logic [63:0] extractBeat(input logic [63:0] lanes,
                                              input beat_t       b);
    return (lanes >> {b.lane, 3'b000}) & sizeMask(b.siz);
  endfunction

  // Right-justified read data -> merged into its lanes of the read buffer.
  function automatic logic [63:0] mergeBeat(input logic [63:0] rbuf,
                                            input logic [63:0] rdata,
                                            input beat_t       b);
    logic [63:0] laneBits;
    laneBits = sizeMask(b.siz) << {b.lane, 3'b000};
    return (rbuf & ~laneBits) | ((rdata & sizeMask(b.siz)) << {b.lane, 3'b000});
  endfunction

  state_t         state_q, state_d;
  logic [AW-4:0]  adrHi_q, adrHi_d;
  logic           we_q, we_d;
  logic [63:0]    wdat_q, wdat_d;
  logic [7:0]     rem_q, rem_d;
  logic [63:0]    rbuf_q, rbuf_d;
  logic           abort_q, abort_d;
  logic           fCyc_q, fCyc_d;
  logic           fStb_q, fStb_d;
  logic           fWe_q, fWe_d;
  logic [AW-1:0]  fAdr_q, fAdr_d;
  logic [1:0]     fSiz_q, fSiz_d;
  logic [63:0]    fDat_q, fDat_d;
  logic           wbsAck_q, wbsAck_d;
  logic [63:0]    wbsDat_q, wbsDat_d;

  beat_t          curBeat;
  beat_t          launchBeat;
  logic [7:0]     remAfter;
  logic [7:0]     launchRem;
  logic [63:0]    launchLanes;
  logic [AW-4:0]  launchHi;
  logic [63:0]    rbufAfter;
  logic           abortNow;
  logic [2:0]     unusedAdrLow;
  logic [7:0]     unusedLaunchMask;

  // The beat in flight is always derived from the lanes still outstanding;
  // rem only changes on an acknowledged beat, so this stays stable in XFER.
  assign curBeat   = pickBeat(rem_q);
  assign remAfter  = rem_q & ~curBeat.mask;
  assign rbufAfter = we_q ? rbuf_q : mergeBeat(rbuf_q, f_dat_i, curBeat);
  assign abortNow  = abort_q | ~wbs_cyc_i;

  // A new beat is launched either straight from the incoming request (IDLE)
  // or from the latched request once the previous beat is acknowledged.
  assign launchRem   = (state_q == IDLE) ? wbs_sel_i : remAfter;
  assign launchLanes = (state_q == IDLE) ? wbs_dat_i : wdat_q;
  assign launchHi    = (state_q == IDLE) ? wbs_adr_i[AW-1:3] : adrHi_q;
  assign launchBeat  = pickBeat(launchRem);

  // Lane position comes from sel on a 64-bit bus; the launch mask is
  // recomputed from rem once the beat is in flight.
  assign unusedAdrLow     = wbs_adr_i[2:0];
  assign unusedLaunchMask = launchBeat.mask;

  // Next-state and output logic: IDLE latches a request and launches the
  // first beat, XFER walks the remaining lanes one acknowledged beat at a
  // time, DONE holds the single Wishbone acknowledge.
  always_comb begin
    state_d  = state_q;
    adrHi_d  = adrHi_q;
    we_d     = we_q;
    wdat_d   = wdat_q;
    rem_d    = rem_q;
    rbuf_d   = rbuf_q;
    abort_d  = abort_q;
    fCyc_d   = fCyc_q;
    fStb_d   = fStb_q;
    fWe_d    = fWe_q;
    fAdr_d   = fAdr_q;
    fSiz_d   = fSiz_q;
    fDat_d   = fDat_q;
    wbsAck_d = wbsAck_q;
    wbsDat_d = wbsDat_q;

    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && !wbsAck_q) begin
          adrHi_d = wbs_adr_i[AW-1:3];
          we_d    = wbs_we_i;
          wdat_d  = wbs_dat_i;
          rem_d   = wbs_sel_i;
          rbuf_d  = '0;
          abort_d = 1'b0;
          if (wbs_sel_i == 8'h00) begin
            // Nothing to move: acknowledge without touching Furcula.
            state_d  = DONE;
            wbsAck_d = 1'b1;
            wbsDat_d = '0;
          end else begin
            state_d = XFER;
            fCyc_d  = 1'b1;
            fStb_d  = 1'b1;
            fWe_d   = wbs_we_i;
            fAdr_d  = {launchHi, launchBeat.lane};
            fSiz_d  = launchBeat.siz;
            fDat_d  = extractBeat(launchLanes, launchBeat);
          end
        end
      end

      XFER: begin
        // Remember a dropped cycle so the abort still happens even if the
        // master raises cyc again before the in-flight beat is acknowledged.
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (f_ack_i) begin
          rem_d  = remAfter;
          rbuf_d = rbufAfter;
          if (abortNow || remAfter == 8'h00) begin
            fCyc_d = 1'b0;
            fStb_d = 1'b0;
            fWe_d  = 1'b0;
            fAdr_d = '0;
            fSiz_d = 2'b00;
            fDat_d = '0;
          end
          if (abortNow) begin
            state_d = IDLE;
            abort_d = 1'b0;
            rem_d   = '0;
          end else if (remAfter == 8'h00) begin
            state_d  = DONE;
            wbsAck_d = 1'b1;
            wbsDat_d = we_q ? 64'h0 : rbufAfter;
          end else begin
            fAdr_d = {launchHi, launchBeat.lane};
            fSiz_d = launchBeat.siz;
            fDat_d = extractBeat(launchLanes, launchBeat);
          end
        end
      end

      DONE: begin
        state_d  = IDLE;
        wbsAck_d = 1'b0;
        wbsDat_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight beat.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      adrHi_q  <= '0;
      we_q     <= 1'b0;
      wdat_q   <= '0;
      rem_q    <= '0;
      rbuf_q   <= '0;
      abort_q  <= 1'b0;
      fCyc_q   <= 1'b0;
      fStb_q   <= 1'b0;
      fWe_q    <= 1'b0;
      fAdr_q   <= '0;
      fSiz_q   <= 2'b00;
      fDat_q   <= '0;
      wbsAck_q <= 1'b0;
      wbsDat_q <= '0;
    end else begin
      state_q  <= state_d;
      adrHi_q  <= adrHi_d;
      we_q     <= we_d;
      wdat_q   <= wdat_d;
      rem_q    <= rem_d;
      rbuf_q   <= rbuf_d;
      abort_q  <= abort_d;
      fCyc_q   <= fCyc_d;
      fStb_q   <= fStb_d;
      fWe_q    <= fWe_d;
      fAdr_q   <= fAdr_d;
      fSiz_q   <= fSiz_d;
      fDat_q   <= fDat_d;
      wbsAck_q <= wbsAck_d;
      wbsDat_q <= wbsDat_d;
    end
  end

  assign wbs_ack_o  = wbsAck_q;
  assign wbs_dat_o  = wbsDat_q;
  assign f_cyc_o    = fCyc_q;
  assign f_stb_o    = fStb_q;
  assign f_we_o     = fWe_q;
  assign f_adr_o    = fAdr_q;
  assign f_siz_o    = fSiz_q;
  assign f_dat_o    = fDat_q;
  assign f_signed_o = 1'b0;

endmodule

// File: tb/tb_wb_furcula_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_furcula_bridge
//
// Purpose:
//   Self-checking bench for wb_furcula_bridge. Directed Wishbone requests
//   push their hand-computed Furcula beats and Wishbone read data into
//   queues; a monitor pops and compares whenever a beat completes or the
//   bridge acknowledges. A Furcula responder acks with a set latency.
// ---------------------------------------------------------------------------
module tb_wb_furcula_bridge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [63:0] wbs_adr_i;
  logic [7:0]  wbs_sel_i;
  logic [63:0] wbs_dat_i;
  logic [63:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        f_cyc_o;
  logic        f_stb_o;
  logic        f_we_o;
  logic [63:0] f_adr_o;
  logic [1:0]  f_siz_o;
  logic        f_signed_o;
  logic [63:0] f_dat_o;
  logic [63:0] f_dat_i;
  logic        f_ack_i;

  typedef struct {
    logic [63:0] adr;
    logic [1:0]  siz;
    logic        we;
    logic [63:0] dat;
  } beatExp_t;

  beatExp_t    beatQ[$];
  logic [63:0] ackQ[$];

  int          checks = 0;
  int          errors = 0;
  int          ackLatency = 0;
  logic [63:0] respData = 64'h0;

  wb_furcula_bridge #(.AW(64)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .f_cyc_o    (f_cyc_o),
    .f_stb_o    (f_stb_o),
    .f_we_o     (f_we_o),
    .f_adr_o    (f_adr_o),
    .f_siz_o    (f_siz_o),
    .f_signed_o (f_signed_o),
    .f_dat_o    (f_dat_o),
    .f_dat_i    (f_dat_i),
    .f_ack_i    (f_ack_i)
  );

  // 10-unit clock
  initial forever #5 clk_i = ~clk_i;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
    end
  endtask

  task automatic expectBeat(input logic [63:0] adr, input logic [1:0] siz,
                            input logic we, input logic [63:0] dat);
    beatExp_t e;
    e.adr = adr;
    e.siz = siz;
    e.we  = we;
    e.dat = dat;
    beatQ.push_back(e);
  endtask

  // Issue one Wishbone request, hold it until acknowledged, and report the
  // number of negative edges from driving the request to seeing the ack.
  task automatic applyStimulus(input logic we, input logic [63:0] adr,
                               input logic [7:0] sel, input logic [63:0] dat,
                               output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    @(posedge clk_i);
    #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_sel_i = sel;
    wbs_dat_i = dat;
    while (!got && cycles < 200) begin
      @(negedge clk_i);
      cycles++;
      if (wbs_ack_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack timeout: no wbs_ack_o for adr %h sel %h", adr, sel);
    end
    @(posedge clk_i);
    #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 8'h00;
    wbs_dat_i = 64'h0;
  endtask

  // Furcula responder: acks a presented beat after ackLatency wait cycles.
  initial begin
    int waitCnt;
    waitCnt = 0;
    f_ack_i = 1'b0;
    f_dat_i = 64'h0;
    forever begin
      @(posedge clk_i);
      #1;
      if (f_ack_i) begin
        f_ack_i = 1'b0;
        waitCnt = 0;
      end
      if (f_stb_o && !reset_i) begin
        if (waitCnt >= ackLatency) begin
          f_ack_i = 1'b1;
          f_dat_i = respData;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Monitor: compares each completing beat and each Wishbone ack against
  // the front of its queue.
  initial begin
    beatExp_t    e;
    logic [63:0] expDat;
    forever begin
      @(negedge clk_i);
      if (!reset_i && f_stb_o && f_ack_i) begin
        if (beatQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected beat: actual adr %h siz %0d, required none",
                   f_adr_o, f_siz_o);
        end else begin
          e = beatQ.pop_front();
          checkOutput("beat f_adr_o", f_adr_o, e.adr);
          checkOutput("beat f_siz_o", 64'(f_siz_o), 64'(e.siz));
          checkOutput("beat f_we_o", 64'(f_we_o), 64'(e.we));
          checkOutput("beat f_dat_o", f_dat_o, e.dat);
          checkOutput("beat f_cyc_o/f_signed_o", 64'({f_cyc_o, f_signed_o}), 64'd2);
        end
      end
      if (!reset_i && wbs_ack_o) begin
        if (ackQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected ack: actual wbs_ack_o 1 dat %h, required none",
                   wbs_dat_o);
        end else begin
          expDat = ackQ.pop_front();
          checkOutput("ack wbs_dat_o", wbs_dat_o, expDat);
        end
      end
    end
  end

  initial begin
    int lat;
    int n;
    bit found;
    reset_i   = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_adr_i = 64'h0;
    wbs_sel_i = 8'h00;
    wbs_dat_i = 64'h0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset cyc/stb/we/signed/ack",
                64'({f_cyc_o, f_stb_o, f_we_o, f_signed_o, wbs_ack_o}), 64'd0);
    checkOutput("reset wbs_dat_o", wbs_dat_o, 64'h0);
    checkOutput("reset f_adr_o", f_adr_o, 64'h0);
    checkOutput("reset f_dat_o", f_dat_o, 64'h0);
    checkOutput("reset f_siz_o", 64'(f_siz_o), 64'd0);
    reset_i = 1'b0;

    // Dword read, immediate ack
    $display("[TB] dword read");
    ackLatency = 0;
    respData   = 64'h0123_4567_89AB_CDEF;
    expectBeat(64'h1000, 2'b11, 1'b0, 64'h0);
    ackQ.push_back(64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b0, 64'h1000, 8'hFF, 64'h0, lat);
    checkOutput("dword read latency", 64'(lat), 64'd3);

    // Word write in the upper half
    $display("[TB] word write");
    expectBeat(64'h200C, 2'b10, 1'b1, 64'hDEAD_BEEF);
    ackQ.push_back(64'h0);
    applyStimulus(1'b1, 64'h2008, 8'hF0, 64'hDEAD_BEEF_0000_0000, lat);
    checkOutput("word write latency", 64'(lat), 64'd3);

    // sel=3C: lane 2 is not word aligned, so two hwords
    $display("[TB] hword pair write");
    expectBeat(64'h3002, 2'b01, 1'b1, 64'hCCDD);
    expectBeat(64'h3004, 2'b01, 1'b1, 64'hAABB);
    ackQ.push_back(64'h0);
    applyStimulus(1'b1, 64'h3000, 8'h3C, 64'h0000_AABB_CCDD_0000, lat);
    checkOutput("hword pair latency", 64'(lat), 64'd4);

    // Sparse byte read; address low bits are ignored, upper read bits masked
    $display("[TB] sparse byte read");
    respData = 64'hAAAA_AAAA_AAAA_AA11;
    expectBeat(64'h5001, 2'b00, 1'b0, 64'h0);
    expectBeat(64'h5003, 2'b00, 1'b0, 64'h0);
    expectBeat(64'h5004, 2'b00, 1'b0, 64'h0);
    expectBeat(64'h5006, 2'b00, 1'b0, 64'h0);
    ackQ.push_back(64'h0011_0011_1100_1100);
    applyStimulus(1'b0, 64'h5005, 8'h5A, 64'h0, lat);
    checkOutput("sparse read latency", 64'(lat), 64'd6);

    // Mixed sizes with two wait states per beat
    $display("[TB] mixed read with wait states");
    ackLatency = 2;
    respData   = 64'hFFFF_FFFF_A5C3_B2E1;
    expectBeat(64'h6001, 2'b00, 1'b0, 64'h0);
    expectBeat(64'h6002, 2'b00, 1'b0, 64'h0);
    expectBeat(64'h6004, 2'b10, 1'b0, 64'h0);
    ackQ.push_back(64'hA5C3_B2E1_00E1_E100);
    applyStimulus(1'b0, 64'h6000, 8'hF6, 64'h0, lat);
    checkOutput("mixed read latency", 64'(lat), 64'd11);

    // Empty select: no beats, ack one cycle after the request
    $display("[TB] empty select");
    ackLatency = 0;
    ackQ.push_back(64'h0);
    applyStimulus(1'b0, 64'h7000, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    checkOutput("empty select latency", 64'(lat), 64'd2);

    // Abort: drop cyc during the second beat of sel=5A
    $display("[TB] abort");
    ackLatency = 2;
    respData   = 64'h22;
    expectBeat(64'hA001, 2'b00, 1'b0, 64'h0);
    expectBeat(64'hA003, 2'b00, 1'b0, 64'h0);
    @(posedge clk_i);
    #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = 64'hA000;
    wbs_sel_i = 8'h5A;
    n     = 0;
    found = 1'b0;
    while (!found && n < 50) begin
      @(negedge clk_i);
      n++;
      if (f_stb_o && f_adr_o[2:0] == 3'd3) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL abort second beat: actual not seen, required beat at lane 3");
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_sel_i = 8'h00;
    repeat (12) @(posedge clk_i);
    #1;
    checkOutput("abort beats outstanding", 64'(beatQ.size()), 64'd0);
    checkOutput("abort f_cyc_o/f_stb_o", 64'({f_cyc_o, f_stb_o}), 64'd0);

    // Reset in the middle of a beat
    $display("[TB] reset mid-beat");
    ackLatency = 5;
    @(posedge clk_i);
    #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = 64'h9000;
    wbs_sel_i = 8'hFF;
    @(posedge clk_i);
    #1;
    checkOutput("pre-reset f_stb_o", 64'(f_stb_o), 64'd1);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("reset mid-beat f_cyc_o/f_stb_o", 64'({f_cyc_o, f_stb_o}), 64'd0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_sel_i = 8'h00;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Recovery after reset: low word write, upper write lanes masked off
    $display("[TB] write after reset");
    ackLatency = 1;
    expectBeat(64'h8000, 2'b10, 1'b1, 64'h1234_5678);
    ackQ.push_back(64'h0);
    applyStimulus(1'b1, 64'h8000, 8'h0F, 64'hFFFF_FFFF_1234_5678, lat);
    checkOutput("write after reset latency", 64'(lat), 64'd4);

    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("beat queue drained", 64'(beatQ.size()), 64'd0);
    checkOutput("ack queue drained", 64'(ackQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
